// File: rtl/wb_arbiter2_pkg.sv
// Shared types and helpers for the two-master pipelined Wishbone arbiter.
package wb_arbiter2_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OWN0  = 3'd1,
    S_OWN1  = 3'd2,
    S_PRE1  = 3'd3,
    S_DRAIN = 3'd4
  } arb_state_t;

  localparam logic LAST_M0 = 1'b0;
  localparam logic LAST_M1 = 1'b1;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  localparam wb_req_t WB_REQ_IDLE = '{
    cyc: 1'b0, stb: 1'b0, we: 1'b0, sel: 4'h0, adr: 32'h0000_0000, dat: 32'h0000_0000
  };

  // Round-robin pick from idle: m0 wins when alone or when m1 held the last grant.
  function automatic logic m0_wins(input logic m0_cyc, input logic m1_cyc, input logic last);
    return m0_cyc && (!m1_cyc || (last == LAST_M1));
  endfunction

endpackage

// File: rtl/wb_arbiter2_txn_counter.sv
// Outstanding-transaction counter: issued requests minus returned acks.
// Acks arriving with nothing in flight are ignored, and issue is refused at saturation.
module wb_txn_counter #(
  parameter int OWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_i,
  input  logic              ack_i,
  output logic [OWIDTH-1:0] count_o,
  output logic              zero_o,
  output logic              sat_o
);

  localparam logic [OWIDTH-1:0] CNT_ZERO = {OWIDTH{1'b0}};
  localparam logic [OWIDTH-1:0] CNT_ONE  = {{(OWIDTH-1){1'b0}}, 1'b1};
  localparam logic [OWIDTH-1:0] CNT_MAX  = {OWIDTH{1'b1}};

  logic [OWIDTH-1:0] count_q;
  logic [OWIDTH-1:0] count_d;
  logic              inc_s;
  logic              dec_s;

  assign inc_s = issue_i && (count_q != CNT_MAX);
  assign dec_s = ack_i && (count_q != CNT_ZERO);

  always_comb begin
    count_d = count_q;
    case ({inc_s, dec_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == CNT_ZERO);
  assign sat_o   = (count_q == CNT_MAX);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave pipelined Wishbone arbiter. m0 (data) has priority and
// may preempt m1 (fetch); acks left over when a master abandons a cycle are drained.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int OWIDTH  = 4,
  parameter bit PREEMPT = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [31:0]       m0_adr_i,
  input  logic [31:0]       m0_dat_i,
  output logic [31:0]       m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_stall_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [31:0]       m1_adr_i,
  input  logic [31:0]       m1_dat_i,
  output logic [31:0]       m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_stall_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic [31:0]       s_adr_o,
  output logic [31:0]       s_dat_o,
  input  logic [31:0]       s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_stall_i,
  output arb_state_t        state_o,
  output logic [OWIDTH-1:0] count_o
);

  localparam logic [OWIDTH-1:0] CNT_ONE = {{(OWIDTH-1){1'b0}}, 1'b1};

  arb_state_t        state_q;
  logic              last_q;
  wb_req_t           m0_req_s;
  wb_req_t           m1_req_s;
  wb_req_t           fwd_s;
  logic [OWIDTH-1:0] count_s;
  logic              zero_s;
  logic              sat_s;
  logic              issue_s;
  logic              drain_done_s;

  assign m0_req_s = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                      sel: m0_sel_i, adr: m0_adr_i, dat: m0_dat_i};
  assign m1_req_s = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                      sel: m1_sel_i, adr: m1_adr_i, dat: m1_dat_i};

  assign issue_s = s_stb_o && !s_stall_i;
  // The final ack of a drain lets us leave on the same edge it is counted.
  assign drain_done_s = zero_s || ((count_s == CNT_ONE) && s_ack_i);

  wb_txn_counter #(.OWIDTH(OWIDTH)) u_txn_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .issue_i (issue_s),
    .ack_i   (s_ack_i),
    .count_o (count_s),
    .zero_o  (zero_s),
    .sat_o   (sat_s)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      last_q  <= LAST_M1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (m0_wins(m0_cyc_i, m1_cyc_i, last_q)) begin
            state_q <= S_OWN0;
            last_q  <= LAST_M0;
          end else if (m1_cyc_i) begin
            state_q <= S_OWN1;
            last_q  <= LAST_M1;
          end
        end
        S_OWN0: begin
          if (!m0_cyc_i) state_q <= zero_s ? S_IDLE : S_DRAIN;
        end
        S_OWN1: begin
          if (!m1_cyc_i) state_q <= zero_s ? S_IDLE : S_DRAIN;
          else if (PREEMPT && m0_cyc_i) state_q <= S_PRE1;
        end
        S_PRE1: begin
          if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              state_q <= S_OWN1;
              last_q  <= LAST_M1;
            end else begin
              state_q <= zero_s ? S_IDLE : S_DRAIN;
            end
          end else if (zero_s) begin
            state_q <= S_OWN0;
            last_q  <= LAST_M0;
          end else if (!m1_cyc_i) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_done_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Steer the owner onto the slave; everyone else is held off with stall and no ack.
  always_comb begin
    fwd_s      = WB_REQ_IDLE;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    case (state_q)
      S_OWN0: begin
        fwd_s      = m0_req_s;
        fwd_s.stb  = m0_req_s.cyc && m0_req_s.stb && !sat_s;
        m0_stall_o = s_stall_i || sat_s;
        m0_ack_o   = s_ack_i && !zero_s;
      end
      S_OWN1: begin
        fwd_s      = m1_req_s;
        fwd_s.stb  = m1_req_s.cyc && m1_req_s.stb && !sat_s;
        m1_stall_o = s_stall_i || sat_s;
        m1_ack_o   = s_ack_i && !zero_s;
      end
      S_PRE1: begin
        fwd_s     = m1_req_s;
        fwd_s.cyc = 1'b1;
        fwd_s.stb = 1'b0;
        m1_ack_o  = s_ack_i && !zero_s;
      end
      S_DRAIN: begin
        fwd_s.cyc = 1'b1;
      end
      default: begin
        fwd_s = WB_REQ_IDLE;
      end
    endcase
  end

  assign s_cyc_o  = fwd_s.cyc;
  assign s_stb_o  = fwd_s.stb;
  assign s_we_o   = fwd_s.we;
  assign s_sel_o  = fwd_s.sel;
  assign s_adr_o  = fwd_s.adr;
  assign s_dat_o  = fwd_s.dat;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign state_o  = state_q;
  assign count_o  = count_s;

endmodule
